// File: rtl/stream_fifo.sv
// Valid/ready circular-buffer FIFO, any DEPTH >= 2; odata valid the cycle after a push into empty.
// iready drops at count==DEPTH and returns one cycle after a pop; odata holds while ovalid && !oready.
module stream_fifo #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 4,
  parameter int AFULL       = DEPTH - 1,
  parameter int AEMPTY      = 1,
  parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       idata,
  input  logic                   ivalid,
  output logic                   iready,
  output logic [WIDTH-1:0]       odata,
  output logic                   ovalid,
  input  logic                   oready,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   almost_full,
  output logic                   almost_empty
);

  localparam int                     PW       = $clog2(DEPTH);
  localparam logic [PW-1:0]          PTR_LAST = PW'(DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] DEPTH_C  = COUNT_WIDTH'(DEPTH);
  localparam logic [COUNT_WIDTH-1:0] AFULL_C  = COUNT_WIDTH'(AFULL);
  localparam logic [COUNT_WIDTH-1:0] AEMPTY_C = COUNT_WIDTH'(AEMPTY);

  logic [WIDTH-1:0]       mem [DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic                   itransfer, otransfer, bypass;
  logic [COUNT_WIDTH-1:0] count_n;

  assign itransfer = ivalid && iready;
  assign otransfer = ovalid && oready;
  assign count_n   = count + COUNT_WIDTH'(itransfer) - COUNT_WIDTH'(otransfer);
  assign wr_ptr_n  = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
  assign rd_ptr_n  = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
  // The incoming word is the only one left once any pop is taken, so it goes straight to odata.
  assign bypass    = itransfer && (count == COUNT_WIDTH'(otransfer));

  always_ff @(posedge clock) begin
    if (itransfer && !flush) mem[wr_ptr] <= idata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      odata        <= '0;
      ovalid       <= 1'b0;
      iready       <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else if (flush) begin
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      ovalid       <= 1'b0;
      iready       <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      count        <= count_n;
      iready       <= count_n < DEPTH_C;
      ovalid       <= count_n != '0;
      almost_full  <= count_n >= AFULL_C;
      almost_empty <= count_n <= AEMPTY_C;
      if (itransfer) wr_ptr <= wr_ptr_n;
      if (otransfer) rd_ptr <= rd_ptr_n;
      // Otherwise with count >= 2 the next head was written on an earlier edge.
      if (bypass)
        odata <= idata;
      else if (otransfer && count_n != '0)
        odata <= mem[rd_ptr_n];
    end
  end

endmodule

// File: tb/tb_stream_fifo.sv
// Drives a DEPTH=4 and a DEPTH=3 stream_fifo with shared stimulus and checks both against queue models.
module tb_stream_fifo;

  logic       clock = 1'b0;
  logic       reset, flush, ivalid, oready;
  logic [7:0] idata;

  logic [7:0] a_odata, b_odata;
  logic [2:0] a_count;
  logic [1:0] b_count;
  logic       a_iready, a_ovalid, a_af, a_ae;
  logic       b_iready, b_ovalid, b_af, b_ae;

  always #5 clock = ~clock;

  stream_fifo #(.WIDTH(8), .DEPTH(4), .AFULL(3), .AEMPTY(1)) dut_a (
    .clock(clock), .reset(reset), .flush(flush), .idata(idata), .ivalid(ivalid),
    .iready(a_iready), .odata(a_odata), .ovalid(a_ovalid), .oready(oready),
    .count(a_count), .almost_full(a_af), .almost_empty(a_ae)
  );

  stream_fifo #(.WIDTH(8), .DEPTH(3)) dut_b (
    .clock(clock), .reset(reset), .flush(flush), .idata(idata), .ivalid(ivalid),
    .iready(b_iready), .odata(b_odata), .ovalid(b_ovalid), .oready(oready),
    .count(b_count), .almost_full(b_af), .almost_empty(b_ae)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  bit         started     = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs follow from the contents of each model queue alone.
  task automatic check_all(input string ph);
    chk({ph, " a.count"},  32'(a_count),  qa.size());
    chk({ph, " a.ovalid"}, 32'(a_ovalid), 32'(qa.size() > 0));
    chk({ph, " a.iready"}, 32'(a_iready), 32'(started && qa.size() < 4));
    chk({ph, " a.afull"},  32'(a_af),     32'(qa.size() >= 3));
    chk({ph, " a.aempty"}, 32'(a_ae),     32'(qa.size() <= 1));
    if (qa.size() > 0) chk({ph, " a.odata"}, 32'(a_odata), 32'(qa[0]));
    chk({ph, " b.count"},  32'(b_count),  qb.size());
    chk({ph, " b.ovalid"}, 32'(b_ovalid), 32'(qb.size() > 0));
    chk({ph, " b.iready"}, 32'(b_iready), 32'(started && qb.size() < 3));
    chk({ph, " b.afull"},  32'(b_af),     32'(qb.size() >= 2));
    chk({ph, " b.aempty"}, 32'(b_ae),     32'(qb.size() <= 1));
    if (qb.size() > 0) chk({ph, " b.odata"}, 32'(b_odata), 32'(qb[0]));
  endtask

  task automatic step(input string ph, input bit iv, input logic [7:0] d, input bit ordy, input bit fl);
    bit ia, oa, ib, ob;
    ivalid = iv;
    idata  = d;
    oready = ordy;
    flush  = fl;
    ia = iv && started && qa.size() < 4;
    oa = ordy && qa.size() > 0;
    ib = iv && started && qb.size() < 3;
    ob = ordy && qb.size() > 0;
    @(posedge clock);
    if (fl) begin
      qa.delete();
      qb.delete();
    end else begin
      if (oa) void'(qa.pop_front());
      if (ia) qa.push_back(d);
      if (ob) void'(qb.pop_front());
      if (ib) qb.push_back(d);
    end
    started = 1'b1;
    #1;
    check_all(ph);
  endtask

  initial begin
    reset  = 1'b1;
    flush  = 1'b0;
    ivalid = 1'b0;
    oready = 1'b0;
    idata  = 8'h00;
    #2;
    check_all("reset");
    chk("reset a.odata", 32'(a_odata), 32'h0);
    chk("reset b.odata", 32'(b_odata), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    step("first_edge", 1'b0, 8'h00, 1'b0, 1'b0);

    // Fill three words with the consumer stalled.
    step("t1", 1'b1, 8'h11, 1'b0, 1'b0);
    step("t1", 1'b1, 8'h22, 1'b0, 1'b0);
    step("t1", 1'b1, 8'h33, 1'b0, 1'b0);
    chk("t1 count", 32'(a_count), 32'd3);
    chk("t1 odata", 32'(a_odata), 32'h11);
    chk("t1 afull", 32'(a_af), 32'd1);

    // Full boundary: pending 0x55 waits for the bubble after a single pop.
    step("t2", 1'b1, 8'h44, 1'b0, 1'b0);
    step("t2", 1'b1, 8'h55, 1'b0, 1'b0);
    chk("t2 full iready", 32'(a_iready), 32'd0);
    step("t2", 1'b1, 8'h55, 1'b1, 1'b0);
    chk("t2 pop count", 32'(a_count), 32'd3);
    step("t2", 1'b1, 8'h55, 1'b0, 1'b0);
    chk("t2 refill count", 32'(a_count), 32'd4);
    repeat (5) step("t2 drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Streaming at one word per cycle.
    for (int i = 0; i < 21; i++) step("t3", 1'b1, 8'(8'h60 + i), 1'b1, 1'b0);
    chk("t3 count", 32'(a_count), 32'd1);
    chk("t3 odata", 32'(a_odata), 32'h74);
    step("t3 drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Flush wins over a simultaneous push and pop.
    for (int i = 0; i < 3; i++) step("t5 fill", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    step("t5 flush", 1'b1, 8'hFF, 1'b1, 1'b1);
    chk("t5 count", 32'(a_count), 32'd0);
    chk("t5 iready", 32'(a_iready), 32'd1);
    step("t5 push", 1'b1, 8'h55, 1'b0, 1'b0);
    chk("t5 odata", 32'(a_odata), 32'h55);
    step("t5 drain", 1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset between clock edges.
    step("t6 fill", 1'b1, 8'h01, 1'b0, 1'b0);
    step("t6 fill", 1'b1, 8'h02, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    qa.delete();
    qb.delete();
    started = 1'b0;
    check_all("t6 async");
    #2 reset = 1'b0;
    step("t6 release", 1'b0, 8'h00, 1'b0, 1'b0);

    // Random traffic with stalls and rare flushes; both depths wrap their pointers many times.
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(0, 3) != 0), 8'($urandom), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 59) == 0));
    repeat (5) step("rand drain", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
